pbus_uart_timer: RTL and testbench
==================================

Name: pbus_uart_timer

Overview:
- Peripheral-bus target sitting directly downstream of the data-RAM controller's pbus_addr/pbus_wdata registers.
- Drives the pbus_rdata word that the controller reads back at address 65544.
- Implements a toggle-handshake command port, an 8N1 UART transmitter with a 4-entry byte FIFO, and a free-running 30-bit cycle timer.
- Software writes pbus_wdata first, then pbus_addr with bit 31 toggled to issue one command.

Parameters:
- FIFO_DEPTH, 4, UART TX FIFO entries; power of two, at least 2.
- DIV_RESET, 868, reset value of the baud divisor in clk cycles per bit.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pbus_addr  in  32  command word: [31] req toggle, [8] 1=write/0=read, [7:0] register offset
- pbus_wdata  in  32  write data for the command
- pbus_rdata  out  32  response: [31] ack toggle, [30] err, [29:0] read data
- uart_txd  out  1  serial output, idle high

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it clears everything below on the next clk edge, including mid-frame.
- Reset values:
  - pbus_rdata = 0, ack toggle = 0.
  - uart_txd = 1, UART state IDLE.
  - FIFO empty, overflow = 0, timer = 0, divisor = DIV_RESET.
- Command detect: a command is pending when pbus_addr[31] != ack_q.
  - The command executes in the cycle it is first seen pending.
  - At that edge pbus_rdata is written {~ack_q, err, data} and ack_q flips.
  - Latency: one clk from pbus_addr changing to pbus_rdata[31] matching it.
  - Only one command per toggle. pbus_addr/pbus_wdata changes without a toggle are ignored.
- Registers (offset, access):
  - 0x00 TXDATA, write: push pbus_wdata[7:0]. If FIFO is full with no pop in the same cycle, the byte is dropped and sticky overflow is set. Read returns 0.
  - 0x04 STATUS, read: {25'b0, overflow, tx_busy, fifo_count[2:0]} in [29:0]. Write with wdata[0]=1 clears overflow.
  - 0x08 BAUD, r/w: 16-bit divisor, read zero-extended. Value 0 is treated as 1.
  - 0x0C TIMER, read: timer[29:0]. Any write clears it to 0, with the write taking priority over that cycle's increment.
  - Any other offset: err=1, data=0, no side effect; ack still toggles.
- Timer: +1 every cycle, wraps 2^30-1 -> 0.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: if the FIFO is non-empty, pop a byte, latch the divisor for this frame, go to START. Pop and push in the same cycle are both accepted; count is unchanged.
  - START: txd=0 for div cycles.
  - DATA: 8 bits LSB first, div cycles each; a 3-bit counter indexes the bit.
  - STOP: txd=1 for div cycles, then IDLE, which can pop again next cycle.
  - The baud counter counts div-1 down to 0; each bit lasts exactly div cycles.
  - BAUD writes mid-frame take effect from the next frame.
- tx_busy = (state != IDLE) or FIFO non-empty.
- FIFO: circular pointers of log2(FIFO_DEPTH) bits plus a count register; pointers wrap naturally.

Decomposition:
- Shared package pbus_pkg:
  - register offset constants REG_TXDATA/STATUS/BAUD/TIMER;
  - bit positions PBUS_REQ_BIT=31, PBUS_WR_BIT=8, PBUS_ERR_BIT=30;
  - typedef enum uart_state_t {IDLE, START, DATA, STOP}.
- One sub-module: pbus_byte_fifo.
  - Parameterised depth, 8-bit data.
  - Ports push/pop/din/dout/full/empty/count.
  - Synchronous active-high reset; simultaneous push+pop on full is legal.

Test Plan:
- Reset, then hold → pbus_rdata=0, uart_txd=1; read TIMER after 100 idle cycles returns ~100 (±2 for command latency), ack bit=1.
- BAUD write 4, then TXDATA write 0xA5 → txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; frame is exactly 40 cycles.
- With BAUD=2, write 5 bytes back-to-back while the first is transmitting → first 5 accepted (1 popped, 4 queued); 6th write sets overflow; STATUS reads overflow=1, count=4, busy=1; STATUS write 1 clears overflow.
- Read from offset 0x10 → pbus_rdata[30]=1, data=0, ack toggles; change pbus_wdata without toggling → no new response.
- Assert rst mid-DATA bit 3 → next cycle txd=1, FIFO empty, BAUD=DIV_RESET, ack=0.
- Write BAUD=0, then send 0xFF → each bit lasts 1 cycle; BAUD change mid-frame does not alter the current frame's bit width.

Source files
------------

// File: rtl/pbus_pkg.sv
// Shared definitions for the pbus UART/timer target: register map, command bit positions, UART states.
// Pure declarations; no timing or flow control of its own.
package pbus_pkg;

    localparam logic [7:0] REG_TXDATA = 8'h00;
    localparam logic [7:0] REG_STATUS = 8'h04;
    localparam logic [7:0] REG_BAUD   = 8'h08;
    localparam logic [7:0] REG_TIMER  = 8'h0C;

    localparam int PBUS_REQ_BIT = 31;
    localparam int PBUS_WR_BIT  = 8;
    localparam int PBUS_ERR_BIT = 30;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    // A programmed divisor of zero behaves as one cycle per bit.
    function automatic logic [15:0] eff_div(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/pbus_byte_fifo.sv
// Byte FIFO with circular pointers and a count register; dout shows the head combinationally.
// Push on full is dropped unless a pop happens in the same cycle; pop on empty is ignored.
module pbus_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rptr];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pbus_uart_timer.sv
// Toggle-handshake pbus target: UART 8N1 transmitter behind a byte FIFO plus a free-running 30-bit timer.
// Each req toggle is executed and acked one clk later; TX bytes that find the FIFO full are dropped and flagged.
module pbus_uart_timer
    import pbus_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pbus_addr,
    input  logic [31:0] pbus_wdata,
    output logic [31:0] pbus_rdata,
    output logic        uart_txd
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [31:0]  r_rdata;
    logic         r_ovf;
    logic [15:0]  r_div;
    logic [29:0]  r_timer;
    uart_state_t  r_state;
    logic         r_txd;
    logic [15:0]  r_cnt;
    logic [15:0]  r_frame_div;
    logic [2:0]   r_bit;
    logic [7:0]   r_shift;

    logic         w_cmd;
    logic         w_wr;
    logic [7:0]   w_off;
    logic         w_push;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic [AW:0]  w_count;
    logic [2:0]   w_cnt3;
    logic [7:0]   w_fifo_dout;
    logic         w_tx_busy;
    logic         w_err;
    logic [29:0]  w_rd;
    logic         w_unused;

    assign w_cmd     = (pbus_addr[PBUS_REQ_BIT] != r_rdata[PBUS_REQ_BIT]);
    assign w_wr      = pbus_addr[PBUS_WR_BIT];
    assign w_off     = pbus_addr[7:0];
    assign w_pop     = (r_state == IDLE) && !w_empty;
    assign w_push    = w_cmd && w_wr && (w_off == REG_TXDATA) && (!w_full || w_pop);
    assign w_cnt3    = 3'(w_count);
    assign w_tx_busy = (r_state != IDLE) || !w_empty;
    assign w_unused  = ^{pbus_addr[30:9], pbus_wdata[31:16]};

    assign pbus_rdata = r_rdata;
    assign uart_txd   = r_txd;

    pbus_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (pbus_wdata[7:0]),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Write responses carry no data; only readable registers return a value.
    always_comb begin
        w_err = 1'b0;
        w_rd  = '0;
        case (w_off)
            REG_TXDATA: w_rd = '0;
            REG_STATUS: if (!w_wr) w_rd = {25'd0, r_ovf, w_tx_busy, w_cnt3};
            REG_BAUD:   if (!w_wr) w_rd = {14'd0, r_div};
            REG_TIMER:  if (!w_wr) w_rd = r_timer;
            default:    w_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= '0;
            r_ovf   <= 1'b0;
            r_div   <= DIV_RESET;
        end else if (w_cmd) begin
            r_rdata <= {~r_rdata[PBUS_REQ_BIT], w_err, w_rd};
            if (w_wr) begin
                case (w_off)
                    REG_TXDATA: if (w_full && !w_pop) r_ovf <= 1'b1;
                    REG_STATUS: if (pbus_wdata[0]) r_ovf <= 1'b0;
                    REG_BAUD:   r_div <= pbus_wdata[15:0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (w_cmd && w_wr && (w_off == REG_TIMER)) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 30'd1;
        end
    end

    // Divisor is captured at frame start so BAUD writes only affect later frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_txd       <= 1'b1;
            r_cnt       <= '0;
            r_frame_div <= 16'd1;
            r_bit       <= '0;
            r_shift     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        r_frame_div <= eff_div(r_div);
                        r_cnt       <= eff_div(r_div) - 16'd1;
                        r_shift     <= w_fifo_dout;
                        r_txd       <= 1'b0;
                        r_state     <= START;
                    end
                end
                START: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt   <= r_frame_div - 16'd1;
                        r_bit   <= '0;
                        r_txd   <= r_shift[0];
                        r_state <= DATA;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (r_cnt == 16'd0) begin
                        r_cnt <= r_frame_div - 16'd1;
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                STOP: begin
                    if (r_cnt == 16'd0) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pbus_uart_timer.sv
// Directed bench for pbus_uart_timer: command handshake, register map, UART framing, overflow and reset.
module tb_pbus_uart_timer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pbus_addr;
    logic [31:0] pbus_wdata;
    logic [31:0] pbus_rdata;
    logic        uart_txd;

    logic        tog;
    logic [31:0] rsp;
    logic [31:0] saved;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    pbus_uart_timer u_dut (
        .clk        (clk),
        .rst        (rst),
        .pbus_addr  (pbus_addr),
        .pbus_wdata (pbus_wdata),
        .pbus_rdata (pbus_rdata),
        .uart_txd   (uart_txd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Issue one command by toggling req; response is sampled just after the executing edge.
    task automatic do_cmd(input logic wr, input logic [7:0] off, input logic [31:0] wd);
        @(posedge clk);
        #1;
        pbus_wdata = wd;
        tog        = ~tog;
        pbus_addr  = {tog, 22'd0, wr, off};
        @(posedge clk);
        #1;
        rsp = pbus_rdata;
    endtask

    // Expected line level at sample s (s=1 is the first cycle after the start bit is driven).
    function automatic logic exp_txd(input logic [7:0] b, input int div, input int s);
        int idx;
        idx = (s - 1) / div;
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return b[idx-1];
        else return 1'b1;
    endfunction

    task automatic check_txd(input int first, input int last, input logic [7:0] b,
                             input int div, input string tag);
        for (int s = first; s <= last; s++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s_s%0d", tag, s), {31'd0, uart_txd}, {31'd0, exp_txd(b, div, s)});
        end
    endtask

    initial begin
        rst        = 1'b1;
        pbus_addr  = '0;
        pbus_wdata = '0;
        tog        = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", pbus_rdata, 32'd0);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        rst = 1'b0;

        // Timer after 100 idle cycles plus one cycle of command setup
        repeat (100) @(posedge clk);
        do_cmd(1'b0, 8'h0C, 32'd0);
        check("timer_val", {2'b00, rsp[29:0]}, 32'd101);
        check("timer_ack", {31'd0, rsp[31]}, 32'd1);
        check("timer_err", {31'd0, rsp[30]}, 32'd0);
        do_cmd(1'b0, 8'h08, 32'd0);
        check("baud_reset", rsp, 32'h0000_0364);

        // 0xA5 frame at divisor 4
        do_cmd(1'b1, 8'h08, 32'd4);
        do_cmd(1'b1, 8'h00, 32'h0000_00A5);
        check_txd(1, 41, 8'hA5, 4, "a5");

        // Overflow with divisor 2
        do_cmd(1'b1, 8'h08, 32'd2);
        for (int i = 0; i < 6; i++) do_cmd(1'b1, 8'h00, 32'h10 + i);
        do_cmd(1'b0, 8'h04, 32'd0);
        check("ovf_status", {2'b00, rsp[29:0]}, 32'h1C);
        do_cmd(1'b1, 8'h04, 32'd1);
        do_cmd(1'b0, 8'h04, 32'd0);
        check("ovf_cleared", {2'b00, rsp[29:0]}, 32'h0C);
        repeat (150) @(posedge clk);
        do_cmd(1'b0, 8'h04, 32'd0);
        check("drained", {2'b00, rsp[29:0]}, 32'h0);

        // Unmapped offset, then changes without a toggle
        do_cmd(1'b0, 8'h10, 32'd0);
        check("bad_err", {31'd0, rsp[30]}, 32'd1);
        check("bad_data", {2'b00, rsp[29:0]}, 32'd0);
        check("bad_ack", {31'd0, rsp[31]}, {31'd0, tog});
        saved = rsp;
        pbus_wdata      = 32'h0000_DEAD;
        pbus_addr[8:0]  = 9'h100;
        repeat (4) @(posedge clk);
        #1;
        check("no_toggle_hold", pbus_rdata, saved);
        do_cmd(1'b0, 8'h04, 32'd0);
        check("no_toggle_nopush", {2'b00, rsp[29:0]}, 32'h0);

        // Reset in the middle of data bit 3
        do_cmd(1'b1, 8'h08, 32'd4);
        do_cmd(1'b1, 8'h00, 32'h0000_00A5);
        do_cmd(1'b1, 8'h00, 32'h0000_0011);
        check_txd(3, 18, 8'hA5, 4, "mid");
        rst       = 1'b1;
        pbus_addr = '0;
        tog       = 1'b0;
        @(posedge clk);
        #1;
        check("mrst_txd", {31'd0, uart_txd}, 32'd1);
        check("mrst_rdata", pbus_rdata, 32'd0);
        rst = 1'b0;
        do_cmd(1'b0, 8'h04, 32'd0);
        check("mrst_status", {2'b00, rsp[29:0]}, 32'h0);
        check("mrst_ack", {31'd0, rsp[31]}, 32'd1);
        do_cmd(1'b0, 8'h08, 32'd0);
        check("mrst_baud", {2'b00, rsp[29:0]}, 32'h364);

        // Divisor 0 behaves as 1
        do_cmd(1'b1, 8'h08, 32'd0);
        do_cmd(1'b0, 8'h08, 32'd0);
        check("baud_zero_rd", {2'b00, rsp[29:0]}, 32'h0);
        do_cmd(1'b1, 8'h00, 32'h0000_00FF);
        check_txd(1, 11, 8'hFF, 1, "ff");

        // BAUD change during a frame applies to the next frame only
        do_cmd(1'b1, 8'h08, 32'd3);
        do_cmd(1'b1, 8'h00, 32'h0000_000E);
        do_cmd(1'b1, 8'h08, 32'd1);
        check_txd(3, 31, 8'h0E, 3, "d3");
        do_cmd(1'b1, 8'h00, 32'h0000_0002);
        check_txd(1, 11, 8'h02, 1, "d1");

        // Timer write clears it
        do_cmd(1'b1, 8'h0C, 32'd0);
        do_cmd(1'b0, 8'h0C, 32'd0);
        check("timer_clear", {2'b00, rsp[29:0]}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
